// File: rtl/dram_cache_pkg.sv
// -----------------------------------------------------------------------------
// dram_cache_pkg
// Shared constants and types for the DRAM-cache read path.
//   ROB_DATA_WIDTH : read data width      (default 32)
//   ROB_ID_WIDTH   : host AXI ID width    (default 4)
//   ROB_TID_WIDTH  : internal tid width   (default 4)
//   ROB_DEPTH      : reorder-buffer entries, 2**ROB_TID_WIDTH
//   rob_entry_t    : {id, data} as returned on the host R channel
//   completion_t   : {tid, data} as delivered by the hit and miss paths
//   RRESP_OKAY     : AXI OKAY response code
// -----------------------------------------------------------------------------
package dram_cache_pkg;

    localparam int ROB_DATA_WIDTH = 32;
    localparam int ROB_ID_WIDTH   = 4;
    localparam int ROB_TID_WIDTH  = 4;

    localparam int ROB_DEPTH = 2 ** ROB_TID_WIDTH;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0]   id;
        logic [ROB_DATA_WIDTH-1:0] data;
    } rob_entry_t;

    typedef struct packed {
        logic [ROB_TID_WIDTH-1:0]  tid;
        logic [ROB_DATA_WIDTH-1:0] data;
    } completion_t;

endpackage

// File: rtl/rob_data_ram.sv
// -----------------------------------------------------------------------------
// rob_data_ram
// Data storage for the reorder buffer: DEPTH x DATA_WIDTH, two write ports and
// one asynchronous read port.
//   clk                          : clock
//   hit_we/hit_addr/hit_data     : write port for read-hit completions
//   miss_we/miss_addr/miss_data  : write port for refill completions
//   rd_addr/rd_data              : combinational read (driven by ROB head)
// On an address collision the hit port's data is kept.
// -----------------------------------------------------------------------------
module rob_data_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  hit_we,
    input  logic [ADDR_WIDTH-1:0] hit_addr,
    input  logic [DATA_WIDTH-1:0] hit_data,
    input  logic                  miss_we,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic [DATA_WIDTH-1:0] miss_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; validity is tracked by the done
    // bits in the controller, so resetting the data would only cost muxes.
    // NOTE: non-blocking assignments in clocked logic; the later hit write
    // therefore overrides the miss write when both address the same word.
    always_ff @(posedge clk) begin
        if (miss_we) mem[miss_addr] <= miss_data;
        if (hit_we)  mem[hit_addr]  <= hit_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rob_ctrl.sv
// -----------------------------------------------------------------------------
// rob_ctrl
// Reorder buffer between the DRAM-cache controller and the host AXI R channel.
// Allocates one tid per accepted host read, accepts out-of-order completions
// from the hit and miss paths, and returns data strictly in allocation order
// with the original ARID restored.
//   alloc_valid_i/alloc_id_i    : host AR accepted, ARID to restore
//   alloc_ready_o/alloc_tid_o   : slot available / tid granted (tail index)
//   afull_o                     : free entries <= AFULL_MARGIN
//   hit_wren_i/hit_data_i       : read-hit completion {tid, data}
//   miss_wren_i/miss_data_i     : refill completion {tid, data}
//   rid_o/rdata_o/rresp_o/rlast_o/rvalid_o/rready_i : host R channel
//   err_o                       : sticky protocol error
// Optional feature macro: ROB_ERR_CHECK_EN builds the protocol checker that
// drives err_o; without it err_o is tied to 0.
// Reset is synchronous, active-low.
// -----------------------------------------------------------------------------
module rob_ctrl
    import dram_cache_pkg::*;
#(
    parameter int DATA_WIDTH   = ROB_DATA_WIDTH,
    parameter int ID_WIDTH     = ROB_ID_WIDTH,
    parameter int TID_WIDTH    = ROB_TID_WIDTH,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid_i,
    input  logic [ID_WIDTH-1:0]           alloc_id_i,
    output logic                          alloc_ready_o,
    output logic [TID_WIDTH-1:0]          alloc_tid_o,
    output logic                          afull_o,
    input  logic                          hit_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] hit_data_i,
    input  logic                          miss_wren_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] miss_data_i,
    output logic [ID_WIDTH-1:0]           rid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [1:0]                    rresp_o,
    output logic                          rlast_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic                          err_o
);

    localparam int DEPTH = 2 ** TID_WIDTH;
    localparam int PW    = TID_WIDTH + 1;   // one extra wrap bit for full/empty

    logic [PW-1:0]         head_q, tail_q, head_d, tail_d, occ_d;
    logic [DEPTH-1:0]      done_q;
    logic [ID_WIDTH-1:0]   id_mem [DEPTH];
    logic                  alloc_ready_q, afull_q, rvalid_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [TID_WIDTH-1:0]  head_idx, tail_idx, hit_tid, miss_tid;
    logic [DATA_WIDTH-1:0] hit_dat, miss_dat, ram_rd;
    logic                  do_alloc, do_load, miss_accept;

    assign head_idx = head_q[TID_WIDTH-1:0];
    assign tail_idx = tail_q[TID_WIDTH-1:0];
    assign hit_tid  = hit_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign hit_dat  = hit_data_i[DATA_WIDTH-1:0];
    assign miss_tid = miss_data_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign miss_dat = miss_data_i[DATA_WIDTH-1:0];

    // On a tid collision the miss write is dropped entirely.
    assign miss_accept = miss_wren_i && !(hit_wren_i && (hit_tid == miss_tid));
    assign do_alloc    = alloc_valid_i && alloc_ready_q;
    // The empty guard keeps stale done bits (e.g. a completion landing after
    // reset) from ever producing an R beat.
    assign do_load     = done_q[head_idx] && (head_q != tail_q) &&
                         (!rvalid_q || rready_i);

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally) so no latch is inferred.
    always_comb begin
        head_d = head_q + PW'(do_load);
        tail_d = tail_q + PW'(do_alloc);
        occ_d  = tail_d - head_d;
    end

    rob_data_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (TID_WIDTH)
    ) u_data_ram (
        .clk       (clk),
        .hit_we    (hit_wren_i),
        .hit_addr  (hit_tid),
        .hit_data  (hit_dat),
        .miss_we   (miss_accept),
        .miss_addr (miss_tid),
        .miss_data (miss_dat),
        .rd_addr   (head_idx),
        .rd_data   (ram_rd)
    );

    always_ff @(posedge clk) begin
        if (do_alloc) id_mem[tail_idx] <= alloc_id_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q        <= '0;
            tail_q        <= '0;
            done_q        <= '0;
            alloc_ready_q <= 1'b1;
            afull_q       <= 1'b0;
            rvalid_q      <= 1'b0;
            rid_q         <= '0;
            rdata_q       <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            alloc_ready_q <= (occ_d != PW'(DEPTH));
            afull_q       <= (occ_d >= PW'(DEPTH - AFULL_MARGIN));

            // Ordering matters: completions override the alloc clear, and the
            // drain clear overrides both.
            if (do_alloc)    done_q[tail_idx] <= 1'b0;
            if (hit_wren_i)  done_q[hit_tid]  <= 1'b1;
            if (miss_accept) done_q[miss_tid] <= 1'b1;

            if (do_load) begin
                done_q[head_idx] <= 1'b0;
                rvalid_q         <= 1'b1;
                rid_q            <= id_mem[head_idx];
                rdata_q          <= ram_rd;
            end else if (rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign alloc_ready_o = alloc_ready_q;
    assign alloc_tid_o   = tail_idx;
    assign afull_o       = afull_q;
    assign rvalid_o      = rvalid_q;
    assign rid_o         = rid_q;
    assign rdata_o       = rdata_q;
    assign rresp_o       = RRESP_OKAY;
    assign rlast_o       = 1'b1;

`ifdef ROB_ERR_CHECK_EN
    logic [PW-1:0]        occ_q;
    logic [TID_WIDTH-1:0] hit_off, miss_off;
    logic                 hit_bad, miss_bad, tid_clash, alloc_bad, err_q;

    // A tid is live when its distance from head is below the occupancy.
    always_comb begin
        occ_q     = tail_q - head_q;
        hit_off   = hit_tid - head_idx;
        miss_off  = miss_tid - head_idx;
        hit_bad   = hit_wren_i  && (({1'b0, hit_off}  >= occ_q) || done_q[hit_tid]);
        miss_bad  = miss_wren_i && (({1'b0, miss_off} >= occ_q) || done_q[miss_tid]);
        tid_clash = hit_wren_i && miss_wren_i && (hit_tid == miss_tid);
        alloc_bad = alloc_valid_i && !alloc_ready_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (hit_bad || miss_bad || tid_clash || alloc_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_ctrl
// Directed self-checking bench for rob_ctrl at DATA_WIDTH=32, ID_WIDTH=4,
// TID_WIDTH=4 (DEPTH=16), AFULL_MARGIN=2. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_rob_ctrl;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TW = 4;
`ifdef ROB_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_valid_i;
    logic [IW-1:0] alloc_id_i;
    logic          alloc_ready_o;
    logic [TW-1:0] alloc_tid_o;
    logic          afull_o;
    logic          hit_wren_i;
    logic [TW+DW-1:0] hit_data_i;
    logic          miss_wren_i;
    logic [TW+DW-1:0] miss_data_i;
    logic [IW-1:0] rid_o;
    logic [DW-1:0] rdata_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic          rvalid_o;
    logic          rready_i;
    logic          err_o;

    int n_cmp = 0;
    int n_bad = 0;

    rob_ctrl #(
        .DATA_WIDTH   (DW),
        .ID_WIDTH     (IW),
        .TID_WIDTH    (TW),
        .AFULL_MARGIN (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid_i (alloc_valid_i),
        .alloc_id_i    (alloc_id_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_tid_o   (alloc_tid_o),
        .afull_o       (afull_o),
        .hit_wren_i    (hit_wren_i),
        .hit_data_i    (hit_data_i),
        .miss_wren_i   (miss_wren_i),
        .miss_data_i   (miss_data_i),
        .rid_o         (rid_o),
        .rdata_o       (rdata_o),
        .rresp_o       (rresp_o),
        .rlast_o       (rlast_o),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid_i = 1'b0;
        alloc_id_i    = '0;
        hit_wren_i    = 1'b0;
        hit_data_i    = '0;
        miss_wren_i   = 1'b0;
        miss_data_i   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rready_i = 1'b1;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [IW-1:0] id);
        alloc_valid_i = 1'b1;
        alloc_id_i    = id;
        tick();
        alloc_valid_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rready_i = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        n_cmp++; if (alloc_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_alloc_ready: got %b want 1", alloc_ready_o); end
        n_cmp++; if (alloc_tid_o !== 4'd0)   begin n_bad++; $display("FAIL rst_alloc_tid: got %0d want 0", alloc_tid_o); end
        n_cmp++; if (afull_o !== 1'b0)       begin n_bad++; $display("FAIL rst_afull: got %b want 0", afull_o); end
        n_cmp++; if (rvalid_o !== 1'b0)      begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", rvalid_o); end
        n_cmp++; if (rid_o !== 4'd0)         begin n_bad++; $display("FAIL rst_rid: got %0h want 0", rid_o); end
        n_cmp++; if (rdata_o !== 32'd0)      begin n_bad++; $display("FAIL rst_rdata: got %0h want 0", rdata_o); end
        n_cmp++; if (rresp_o !== 2'b00)      begin n_bad++; $display("FAIL rst_rresp: got %b want 00", rresp_o); end
        n_cmp++; if (rlast_o !== 1'b1)       begin n_bad++; $display("FAIL rst_rlast: got %b want 1", rlast_o); end
        n_cmp++; if (err_o !== 1'b0)         begin n_bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        rst_n = 1'b1;
    endtask

    // Allocate ids 3,5,7; complete 2,0,1; data returns in allocation order.
    task automatic test_in_order();
        logic [IW-1:0] exp_id [3];
        logic [DW-1:0] exp_dt [3];
        exp_id[0] = 4'd3; exp_id[1] = 4'd5; exp_id[2] = 4'd7;
        exp_dt[0] = 32'hA; exp_dt[1] = 32'hB; exp_dt[2] = 32'hC;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (alloc_tid_o !== 4'(i)) begin n_bad++; $display("FAIL ord_tid[%0d]: got %0d want %0d", i, alloc_tid_o, i); end
            alloc(exp_id[i]);
        end
        hit_wren_i = 1'b1; hit_data_i = {4'd2, 32'hC};
        tick();
        hit_data_i = {4'd0, 32'hA};
        tick();
        // done[0] set at this edge; beat appears only after the next one
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL ord_latency: got rvalid %b want 0", rvalid_o); end
        hit_wren_i = 1'b0;
        miss_wren_i = 1'b1; miss_data_i = {4'd1, 32'hB};
        tick();
        miss_wren_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== exp_id[i] || rdata_o !== exp_dt[i]) begin
                n_bad++; $display("FAIL ord_beat[%0d]: got v=%b id=%0h d=%0h want v=1 id=%0h d=%0h", i, rvalid_o, rid_o, rdata_o, exp_id[i], exp_dt[i]);
            end
            tick();
        end
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL ord_drained: got rvalid %b want 0", rvalid_o); end
    endtask

    // Fill all 16 slots, check afull/ready thresholds, drain one, wrap to tid 0.
    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (alloc_tid_o !== 4'(i)) begin n_bad++; $display("FAIL full_tid[%0d]: got %0d want %0d", i, alloc_tid_o, i); end
            alloc(4'(15 - i));
            n_cmp++; if (afull_o !== (i + 1 >= 14)) begin n_bad++; $display("FAIL full_afull[occ=%0d]: got %b want %b", i + 1, afull_o, (i + 1 >= 14)); end
            n_cmp++; if (alloc_ready_o !== (i + 1 != 16)) begin n_bad++; $display("FAIL full_ready[occ=%0d]: got %b want %b", i + 1, alloc_ready_o, (i + 1 != 16)); end
        end
        // Request while full must be ignored (occupancy stays 16).
        alloc(4'hE);
        n_cmp++; if (alloc_ready_o !== 1'b0 || afull_o !== 1'b1) begin n_bad++; $display("FAIL full_reject: got ready=%b afull=%b want ready=0 afull=1", alloc_ready_o, afull_o); end
        n_cmp++; if (err_o !== ERR_EN) begin n_bad++; $display("FAIL full_err: got %b want %b", err_o, ERR_EN); end
        hit_wren_i = 1'b1; hit_data_i = {4'd0, 32'h55};
        tick();
        hit_wren_i = 1'b0;
        n_cmp++; if (alloc_ready_o !== 1'b0 || rvalid_o !== 1'b0) begin n_bad++; $display("FAIL full_pre_drain: got ready=%b rvalid=%b want 0/0", alloc_ready_o, rvalid_o); end
        tick();
        n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'hF || rdata_o !== 32'h55) begin n_bad++; $display("FAIL full_drain_beat: got v=%b id=%0h d=%0h want v=1 id=f d=55", rvalid_o, rid_o, rdata_o); end
        n_cmp++; if (alloc_ready_o !== 1'b1 || afull_o !== 1'b1) begin n_bad++; $display("FAIL full_after_drain: got ready=%b afull=%b want 1/1", alloc_ready_o, afull_o); end
        n_cmp++; if (alloc_tid_o !== 4'd0) begin n_bad++; $display("FAIL full_wrap_tid: got %0d want 0", alloc_tid_o); end
        alloc(4'h9);
        n_cmp++; if (alloc_ready_o !== 1'b0 || rvalid_o !== 1'b0) begin n_bad++; $display("FAIL full_refill: got ready=%b rvalid=%b want 0/0", alloc_ready_o, rvalid_o); end
    endtask

    // Hit and miss complete different tids in one cycle; both drain back to back.
    task automatic test_back_to_back();
        do_reset();
        alloc(4'd1);
        alloc(4'd2);
        hit_wren_i  = 1'b1; hit_data_i  = {4'd1, 32'h11};
        miss_wren_i = 1'b1; miss_data_i = {4'd0, 32'h22};
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'd1 || rdata_o !== 32'h22) begin n_bad++; $display("FAIL b2b_first: got v=%b id=%0h d=%0h want v=1 id=1 d=22", rvalid_o, rid_o, rdata_o); end
        tick();
        n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'd2 || rdata_o !== 32'h11) begin n_bad++; $display("FAIL b2b_second: got v=%b id=%0h d=%0h want v=1 id=2 d=11", rvalid_o, rid_o, rdata_o); end
        tick();
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got rvalid %b want 0", rvalid_o); end
        // Equal tids in one cycle: hit data kept, miss dropped (next tid is 2).
        n_cmp++; if (alloc_tid_o !== 4'd2) begin n_bad++; $display("FAIL eq_tid_grant: got %0d want 2", alloc_tid_o); end
        alloc(4'd6);
        hit_wren_i  = 1'b1; hit_data_i  = {4'd2, 32'h33};
        miss_wren_i = 1'b1; miss_data_i = {4'd2, 32'h44};
        tick();
        idle_inputs();
        n_cmp++; if (err_o !== ERR_EN) begin n_bad++; $display("FAIL eq_tid_err: got %b want %b", err_o, ERR_EN); end
        tick();
        n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'd6 || rdata_o !== 32'h33) begin n_bad++; $display("FAIL eq_tid_beat: got v=%b id=%0h d=%0h want v=1 id=6 d=33", rvalid_o, rid_o, rdata_o); end
    endtask

    // R held stable under back-pressure; exactly one transfer per accepted beat.
    task automatic test_backpressure();
        do_reset();
        rready_i = 1'b0;
        alloc(4'd9);
        alloc(4'd10);
        hit_wren_i  = 1'b1; hit_data_i  = {4'd0, 32'hD0};
        miss_wren_i = 1'b1; miss_data_i = {4'd1, 32'hD1};
        tick();
        idle_inputs();
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'd9 || rdata_o !== 32'hD0) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b id=%0h d=%0h want v=1 id=9 d=d0", k, rvalid_o, rid_o, rdata_o); end
            tick();
        end
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'd10 || rdata_o !== 32'hD1) begin n_bad++; $display("FAIL bp_next: got v=%b id=%0h d=%0h want v=1 id=a d=d1", rvalid_o, rid_o, rdata_o); end
        tick();
        n_cmp++; if (rvalid_o !== 1'b1 || rid_o !== 4'd10) begin n_bad++; $display("FAIL bp_single_xfer: got v=%b id=%0h want v=1 id=a", rvalid_o, rid_o); end
        rready_i = 1'b1;
        tick();
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL bp_end: got rvalid %b want 0", rvalid_o); end
    endtask

    // Reset with outstanding entries and a pending beat discards everything.
    task automatic test_reset_midop();
        do_reset();
        rready_i = 1'b0;
        for (int i = 0; i < 4; i++) alloc(4'(i + 4));
        hit_wren_i = 1'b1; hit_data_i = {4'd0, 32'hEE};
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got rvalid %b want 1", rvalid_o); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (rvalid_o !== 1'b0 || alloc_tid_o !== 4'd0 || rdata_o !== 32'd0) begin n_bad++; $display("FAIL mid_reset: got v=%b tid=%0d d=%0h want 0/0/0", rvalid_o, alloc_tid_o, rdata_o); end
        n_cmp++; if (alloc_ready_o !== 1'b1 || afull_o !== 1'b0) begin n_bad++; $display("FAIL mid_flags: got ready=%b afull=%b want 1/0", alloc_ready_o, afull_o); end
        hit_wren_i = 1'b1; hit_data_i = {4'd1, 32'hF1};
        tick();
        hit_wren_i = 1'b0;
        miss_wren_i = 1'b1; miss_data_i = {4'd0, 32'hF0};
        tick();
        idle_inputs();
        rready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_no_beat[%0d]: got rvalid %b want 0", k, rvalid_o); end
        end
    endtask

    // Duplicate completion of tid 2 flags err_o (checker builds only).
    task automatic test_err_check();
        do_reset();
        rready_i = 1'b0;
        for (int i = 0; i < 3; i++) alloc(4'(i + 1));
        hit_wren_i = 1'b1; hit_data_i = {4'd2, 32'h2A};
        tick();
        hit_wren_i = 1'b0;
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_legal: got %b want 0", err_o); end
        miss_wren_i = 1'b1; miss_data_i = {4'd2, 32'h2B};
        tick();
        miss_wren_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (err_o !== ERR_EN) begin n_bad++; $display("FAIL err_sticky[%0d]: got %b want %b", k, err_o, ERR_EN); end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_err_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
